icache_fetch_unit: RTL
======================

Name: icache_fetch_unit

Overview:
- Parametrised direct-mapped L1 instruction cache with an integrated miss controller. Successor to the fetch-stage cache wrapper.
- Serves up to FETCH_WIDTH sequential instructions per cycle from flop-based tag/data arrays.
- On a miss, runs a valid/ready line-fill handshake to the memory side.
- Masks lanes that cross a line boundary or are disabled by lane-active or MMU exception inputs.

Parameters:
- FETCH_WIDTH, 4: instructions per fetch; power of 2, 1..8.
- LINE_WORDS, 8: instructions per line; power of 2, >= FETCH_WIDTH.
- SETS, 32: number of lines; power of 2.
- SIZE_PC, 32: PC width.
- INST_BITS, 32: instruction width.
- Derived values:
  - OFS = log2(LINE_WORDS)
  - IDX = log2(SETS)
  - LA = SIZE_PC-2-OFS (line-address width)
  - TAG = LA-IDX

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  invalidate every line.
- fetchReq_i  in  1  fetch request this cycle.
- pc_i  in  SIZE_PC  fetch PC; bits [1:0] ignored.
- laneActive_i  in  FETCH_WIDTH  per-lane enable (dynamic config).
- mmuException_i  in  1  MMU fault for pc_i.
- inst_o  out  FETCH_WIDTH*INST_BITS  lane i at bits [i*INST_BITS +: INST_BITS].
- instValid_o  out  FETCH_WIDTH  per-lane valid.
- icMiss_o  out  1  request not serviced this cycle.
- memReqValid_o  out  1  line-fill request valid.
- memReqReady_i  in  1  memory accepts request.
- memReqAddr_o  out  LA  line address of request.
- memRespValid_i  in  1  fill data valid.
- memRespAddr_i  in  LA  line address of fill data.
- memRespData_i  in  LINE_WORDS*INST_BITS  word w at bits [w*INST_BITS +: INST_BITS].

Behaviour:
- Address split of pc_i:
  - off = pc_i[2+OFS-1:2]
  - idx = pc_i[2+OFS+IDX-1:2+OFS]
  - tag = upper TAG bits
- hit = valid[idx] && tagArr[idx]==tag. Lookup is combinational from arrays, same cycle; zero-cycle hit latency.
- instValid_o[i] = fetchReq_i && hit && !mmuException_i && laneActive_i[i] && (off+i < LINE_WORDS).
- inst_o lane i = data[idx][off+i] when off+i < LINE_WORDS, else 0.
- icMiss_o = fetchReq_i && !hit && !mmuException_i.
- Lookups proceed in every FSM state. A hit during a fill is served normally.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ: on icMiss_o. Latches pendAddr = pc_i[SIZE_PC-1:2+OFS] and clears drop.
  - REQ: memReqValid_o=1, memReqAddr_o=pendAddr.
    - Valid and address stay stable until memReqReady_i; valid is never withdrawn.
    - On ready -> WAIT.
  - WAIT: on memRespValid_i && memRespAddr_i==pendAddr:
    - if !drop: write data, tag and valid for pendAddr.
    - -> IDLE in either case.
  - Responses with a mismatched address are ignored; FSM stays in WAIT.
- New misses arriving while not IDLE raise icMiss_o but are not latched. They re-trigger after return to IDLE because pc is re-presented.
- Fill written at edge N hits at cycle N+1.
- flush_i:
  - Clears all valid bits at the next edge.
  - In REQ or WAIT, also sets drop; the outstanding request still completes its handshake.
  - Flush together with a matching response in WAIT: response discarded, valid stays 0.
- Replacement: a fill overwrites the indexed line unconditionally (direct-mapped).
- memReqAddr_o is 0 when not in REQ.
- Reset (asynchronous, active-low) values:
  - state=IDLE, all valid=0, pendAddr=0, drop=0.
  - memReqValid_o=0, memReqAddr_o=0, instValid_o=0, icMiss_o follows inputs.
  - Data/tag arrays are not reset.
- Reset asserted mid-fill abandons the request. A late response after reset is ignored, because the FSM is in IDLE.

Optional Feature:
- Macro: ICACHE_NEXTLINE_PREFETCH_EN.
- With the macro defined:
  - After a non-dropped demand fill of line L, if line L+1 (modulo 2^LA) is not present, the FSM enters PF_REQ/PF_WAIT and issues one request for L+1 using the same handshake and rules.
  - A demand miss for exactly L+1 during PF_WAIT is served by that fill. Any other demand miss waits for return to IDLE.
  - flush_i sets drop for prefetches as well.
- Without the macro: PF states and their logic are absent; a demand fill returns directly to IDLE.

Test Plan:
- Setup for all scenarios: FETCH_WIDTH=4, LINE_WORDS=8, SETS=32.
1. Miss and fill:
   - Stimulus: reset, then fetch pc=0x1000 with laneActive=1111; hold memReqReady_i=0 for 3 cycles, then 1; respond with addr 0x080 and words 0xA0..0xA7.
   - Required: icMiss_o=1; memReqValid_o=1 with addr 0x080 stable through the stall; the cycle after the fill, inst_o=A0..A3, instValid_o=1111, icMiss_o=0.
2. Line-boundary mask:
   - Stimulus: after scenario 1, fetch pc=0x1018.
   - Required: lanes 0,1 = A6,A7 valid; instValid_o=0011 (lane0 is LSB), lanes 2,3 = 0.
3. Conflict eviction:
   - Stimulus: fetch pc=0x2000 (idx 0, new tag) and fill with 0xB0..; then fetch pc=0x1000.
   - Required: pc=0x1000 misses again and issues addr 0x080.
4. Flush during WAIT:
   - Stimulus: miss on 0x1000, reach WAIT, pulse flush_i, then send a matching response.
   - Required: FSM returns to IDLE; the next fetch of 0x1000 misses and issues a new request.
5. Stale response:
   - Stimulus: in WAIT for 0x080, send a response with addr 0x099.
   - Required: stays WAIT, no array write; the matching response next completes the fill.
6. Lane and exception gating:
   - Stimulus: hit at 0x1000 with laneActive=0101.
   - Required: instValid_o=0101. With mmuException_i=1 on a miss pc, icMiss_o=0 and memReqValid_o stays 0.

Source files
------------

// File: rtl/icache_fetch_unit.sv
// Direct-mapped L1 instruction cache with a single-outstanding line-fill controller.
// Optional next-line prefetch is compiled in with `define ICACHE_NEXTLINE_PREFETCH_EN.
module icache_fetch_unit #(
  parameter int FETCH_WIDTH = 4,
  parameter int LINE_WORDS  = 8,
  parameter int SETS        = 32,
  parameter int SIZE_PC     = 32,
  parameter int INST_BITS   = 32,
  localparam int OFS = $clog2(LINE_WORDS),
  localparam int IDX = $clog2(SETS),
  localparam int LA  = SIZE_PC - 2 - OFS,
  localparam int TAG = LA - IDX
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_i,
  input  logic                            fetchReq_i,
  input  logic [SIZE_PC-1:0]              pc_i,
  input  logic [FETCH_WIDTH-1:0]          laneActive_i,
  input  logic                            mmuException_i,
  output logic [FETCH_WIDTH*INST_BITS-1:0] inst_o,
  output logic [FETCH_WIDTH-1:0]          instValid_o,
  output logic                            icMiss_o,
  output logic                            memReqValid_o,
  input  logic                            memReqReady_i,
  output logic [LA-1:0]                   memReqAddr_o,
  input  logic                            memRespValid_i,
  input  logic [LA-1:0]                   memRespAddr_i,
  input  logic [LINE_WORDS*INST_BITS-1:0] memRespData_i,
  output logic [2:0]                      dbgState_o
);

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2, PF_REQ = 3'd3, PF_WAIT = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, REQ = 3'd1, WAIT = 3'd2} state_t;
`endif

  state_t state, stateNext;

  logic                 validArr [SETS];
  logic [TAG-1:0]       tagArr   [SETS];
  logic [INST_BITS-1:0] dataArr  [SETS][LINE_WORDS];

  logic [LA-1:0]  pendAddr;
  logic           drop;
  logic           fillWe;
  logic           launchDemand;
  logic           launchPf;
  logic           respMatch;

  logic [OFS-1:0] off;
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic           hit;
  logic [OFS:0]   pos;
  logic           unusedPcLow;

  assign off         = pc_i[2 +: OFS];
  assign idx         = pc_i[2+OFS +: IDX];
  assign tag         = pc_i[2+OFS+IDX +: TAG];
  assign unusedPcLow = ^pc_i[1:0];

  assign hit        = validArr[idx] && (tagArr[idx] == tag);
  assign icMiss_o   = fetchReq_i && !hit && !mmuException_i;
  assign dbgState_o = state;
  assign respMatch  = memRespValid_i && (memRespAddr_i == pendAddr);

  // Lanes past the end of the line read as zero and are never valid.
  always_comb begin
    inst_o      = '0;
    instValid_o = '0;
    pos         = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pos = {1'b0, off} + (OFS+1)'(i);
      if (pos < (OFS+1)'(LINE_WORDS)) begin
        inst_o[i*INST_BITS +: INST_BITS] = dataArr[idx][pos[OFS-1:0]];
        instValid_o[i] = fetchReq_i && hit && !mmuException_i && laneActive_i[i];
      end
    end
  end

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
  logic [LA-1:0] nextAddr;
  logic          nextPresent;
  assign nextAddr    = pendAddr + 1'b1;
  assign nextPresent = validArr[nextAddr[IDX-1:0]] && (tagArr[nextAddr[IDX-1:0]] == nextAddr[LA-1:IDX]);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Request handshake: memReqValid_o rises in REQ and holds, with a stable
  // memReqAddr_o, until the cycle memReqReady_i is sampled high; it is never withdrawn.
  always_comb begin
    stateNext     = state;
    memReqValid_o = 1'b0;
    memReqAddr_o  = '0;
    fillWe        = 1'b0;
    launchDemand  = 1'b0;
    launchPf      = 1'b0;
    case (state)
      IDLE: begin
        if (icMiss_o) begin
          stateNext    = REQ;
          launchDemand = 1'b1;
        end
      end
      REQ: begin
        memReqValid_o = 1'b1;
        memReqAddr_o  = pendAddr;
        if (memReqReady_i) stateNext = WAIT;
      end
      WAIT: begin
        if (respMatch) begin
          fillWe    = !drop && !flush_i;
          stateNext = IDLE;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
          if (!drop && !flush_i && !nextPresent) begin
            stateNext = PF_REQ;
            launchPf  = 1'b1;
          end
`endif
        end
      end
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
      PF_REQ: begin
        memReqValid_o = 1'b1;
        memReqAddr_o  = pendAddr;
        if (memReqReady_i) stateNext = PF_WAIT;
      end
      PF_WAIT: begin
        if (respMatch) begin
          fillWe    = !drop && !flush_i;
          stateNext = IDLE;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendAddr <= '0;
      drop     <= 1'b0;
    end else if (launchDemand) begin
      pendAddr <= pc_i[SIZE_PC-1:2+OFS];
      drop     <= 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
    end else if (launchPf) begin
      pendAddr <= nextAddr;
      drop     <= 1'b0;
`endif
    end else if (flush_i && state != IDLE) begin
      drop <= 1'b1;
    end
  end

  // Flush wins over a same-cycle fill so a flushed line never reappears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) validArr[s] <= 1'b0;
    end else if (flush_i) begin
      for (int s = 0; s < SETS; s++) validArr[s] <= 1'b0;
    end else if (fillWe) begin
      validArr[pendAddr[IDX-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fillWe) begin
      tagArr[pendAddr[IDX-1:0]] <= pendAddr[LA-1:IDX];
      for (int w = 0; w < LINE_WORDS; w++)
        dataArr[pendAddr[IDX-1:0]][w] <= memRespData_i[w*INST_BITS +: INST_BITS];
    end
  end

endmodule
